// File: rtl/pps_incr_ctrl_pkg.sv
// pps_incr_ctrl_pkg: shared state encodings, addend select codes and timing defaults
package pps_incr_ctrl_pkg;
  typedef enum logic [1:0] {ACQUIRE, MEASURE, EVAL, LOST} state_t;
  localparam logic [1:0] SEL_NOMINAL = 2'd0;
  localparam logic [1:0] SEL_1_00000 = 2'd1;
  localparam logic [1:0] SEL_1_00001 = 2'd2;
  localparam logic [1:0] SEL_1_00002 = 2'd3;
  localparam int CLK_HZ_DEF = 60000000;
  localparam int TOL_DEF = 30;
endpackage

// File: rtl/pps_edge_sync.sv
// pps_edge_sync: two-flop synchroniser plus edge register giving a one-cycle rising-edge pulse
module pps_edge_sync (
  input  logic clk_pps,
  input  logic reset_pps_n,
  input  logic pps_in,
  output logic pps_rise
);
  logic [2:0] sr;
  always_ff @(posedge clk_pps or negedge reset_pps_n)
    if (!reset_pps_n) begin
      sr <= '0;
      pps_rise <= 1'b0;
    end else begin
      sr <= {sr[1:0], pps_in};
      pps_rise <= sr[1] & ~sr[2];
    end
endmodule

// File: rtl/pps_incr_ctrl.sv
// pps_incr_ctrl: measures PPS windows and steps a_incr_sel toward the code that cancels oscillator error
module pps_incr_ctrl
  import pps_incr_ctrl_pkg::*;
#(
  parameter int CLK_HZ   = CLK_HZ_DEF,
  parameter int WIN_SECS = 4,
  parameter int TOL      = TOL_DEF,
  parameter int MIN_CNT  = CLK_HZ * 7 / 8,
  parameter int TIMEOUT  = CLK_HZ * 9 / 8,
  parameter int CNT_W    = 32,
  localparam int SUM_W   = CNT_W + 4
) (
  input  logic                    clk_pps,
  input  logic                    reset_pps_n,
  input  logic                    pps_in,
  input  logic                    button2_pulse,
  output logic [1:0]              a_incr_sel,
  output logic                    sel_update,
  output logic                    locked,
  output logic                    pps_missing,
  output logic                    manual,
  output logic signed [SUM_W-1:0] period_err
);
  localparam logic [SUM_W-1:0] WIN_CLKS = SUM_W'(WIN_SECS * CLK_HZ);
  localparam logic signed [SUM_W-1:0] DB = SUM_W'(WIN_SECS * TOL);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CNT);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [4:0] WIN_LAST = 5'(WIN_SECS - 1);
  logic pps_rise;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] sum;
  logic [4:0] win_cnt;
  logic signed [SUM_W-1:0] err;
  logic [1:0] step_sel, sel_n;
  pps_edge_sync u_sync (
    .clk_pps     (clk_pps),
    .reset_pps_n (reset_pps_n),
    .pps_in      (pps_in),
    .pps_rise    (pps_rise)
  );
  assign err = $signed(sum - WIN_CLKS);
  // positive error means the oscillator runs fast, so step the addend down
  assign step_sel = (err < -DB && a_incr_sel != SEL_1_00002) ? a_incr_sel + 2'd1 :
                    (err > DB && a_incr_sel != SEL_NOMINAL) ? a_incr_sel - 2'd1 : a_incr_sel;
  assign sel_n = button2_pulse ? a_incr_sel + 2'd1 :
                 (state == EVAL && !manual) ? step_sel : a_incr_sel;
  always_ff @(posedge clk_pps or negedge reset_pps_n)
    if (!reset_pps_n) begin
      state <= ACQUIRE;
      cnt <= '0;
      sum <= '0;
      win_cnt <= '0;
      a_incr_sel <= SEL_NOMINAL;
      sel_update <= 1'b0;
      locked <= 1'b0;
      pps_missing <= 1'b0;
      manual <= 1'b0;
      period_err <= '0;
    end else begin
      cnt <= pps_rise ? CNT_W'(1) : (cnt == TMO) ? cnt : cnt + CNT_W'(1);
      a_incr_sel <= sel_n;
      sel_update <= sel_n != a_incr_sel;
      if (button2_pulse) manual <= 1'b1;
      case (state)
        ACQUIRE, LOST:
          if (pps_rise) begin
            state <= MEASURE;
            sum <= '0;
            win_cnt <= '0;
            pps_missing <= 1'b0;
          end else if (cnt == TMO) begin
            state <= LOST;
            pps_missing <= 1'b1;
            locked <= 1'b0;
          end
        MEASURE:
          if (pps_rise && cnt >= MIN_C) begin
            sum <= sum + SUM_W'(cnt);
            win_cnt <= win_cnt + 5'd1;
            if (win_cnt == WIN_LAST) state <= EVAL;
          end else if (pps_rise) begin
            sum <= '0;
            win_cnt <= '0;
          end else if (cnt == TMO) begin
            state <= LOST;
            pps_missing <= 1'b1;
            locked <= 1'b0;
          end
        default: begin
          period_err <= err;
          locked <= err >= -DB && err <= DB;
          sum <= '0;
          win_cnt <= '0;
          state <= MEASURE;
        end
      endcase
    end
endmodule
